// File: rtl/demux2r_stream_if.sv
// Stream bundle for the 2-way demux: one upstream port, two downstream ports and per-channel push counters.
interface demux2r_stream_if #(
  parameter int dw = 8
);
  logic [dw-1:0] in_data;
  logic          in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [dw-1:0] out0_data;
  logic          out0_valid;
  logic          out0_ready;
  logic [dw-1:0] out1_data;
  logic          out1_valid;
  logic          out1_ready;
  logic [7:0]    cnt0;
  logic [7:0]    cnt1;

  // The demux itself sits on the slave side.
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );

  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid, cnt0, cnt1
  );
endinterface

// File: rtl/demux2r_stream.sv
// Routes each upstream word into one of two 2-entry FIFOs by in_sel; words appear downstream 1 cycle after acceptance.
// in_ready reflects only the selected FIFO's current occupancy (no pop pass-through), so a full channel stalls only its own words.
module demux2r_stream #(
  parameter int dw = 8
) (
  input logic              clk,
  input logic              reset_n,
  demux2r_stream_if.slave  bus
);

  logic [dw-1:0] mem    [2][2];
  logic          rd_ptr [2];
  logic          wr_ptr [2];
  logic [1:0]    occ    [2];
  logic [7:0]    cnt    [2];

  logic [1:0] push;
  logic [1:0] pop;
  logic [1:0] out_ready;
  logic       accept;

  assign out_ready = {bus.out1_ready, bus.out0_ready};
  assign accept    = (occ[bus.in_sel] != 2'd2);

  always_comb begin
    push = '0;
    pop  = '0;
    for (int c = 0; c < 2; c++) begin
      push[c] = bus.in_valid && accept && (bus.in_sel == 1'(c));
      pop[c]  = (occ[c] != 2'd0) && out_ready[c];
    end
  end

  // Data entries are cleared on reset too, so the head word reads zero while empty after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < 2; c++) begin
        mem[c][0] <= '0;
        mem[c][1] <= '0;
        rd_ptr[c] <= 1'b0;
        wr_ptr[c] <= 1'b0;
        occ[c]    <= 2'd0;
        cnt[c]    <= 8'd0;
      end
    end else begin
      for (int c = 0; c < 2; c++) begin
        if (push[c]) begin
          mem[c][wr_ptr[c]] <= bus.in_data;
          wr_ptr[c]         <= ~wr_ptr[c];
          cnt[c]            <= cnt[c] + 8'd1;
        end
        if (pop[c]) begin
          rd_ptr[c] <= ~rd_ptr[c];
        end
        occ[c] <= occ[c] + {1'b0, push[c]} - {1'b0, pop[c]};
      end
    end
  end

  assign bus.in_ready   = accept;
  assign bus.out0_data  = mem[0][rd_ptr[0]];
  assign bus.out0_valid = (occ[0] != 2'd0);
  assign bus.out1_data  = mem[1][rd_ptr[1]];
  assign bus.out1_valid = (occ[1] != 2'd0);
  assign bus.cnt0       = cnt[0];
  assign bus.cnt1       = cnt[1];

endmodule

// File: tb/tb_demux2r_stream.sv
// Bench for demux2r_stream: queue-based channel model checked every cycle plus directed literal checkpoints.
module tb_demux2r_stream;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;

  demux2r_stream_if #(.dw(8)) bus ();

  demux2r_stream #(.dw(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: each channel is an ordered queue of at most two words.
  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  int         m_cnt0;
  int         m_cnt1;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q0.delete();
      q1.delete();
      m_cnt0 = 0;
      m_cnt1 = 0;
    end else begin
      automatic bit take0 = bus.in_valid && !bus.in_sel && (q0.size() < 2);
      automatic bit take1 = bus.in_valid &&  bus.in_sel && (q1.size() < 2);
      if (bus.out0_ready && q0.size() > 0) void'(q0.pop_front());
      if (bus.out1_ready && q1.size() > 0) void'(q1.pop_front());
      if (take0) begin q0.push_back(bus.in_data); m_cnt0 = (m_cnt0 + 1) % 256; end
      if (take1) begin q1.push_back(bus.in_data); m_cnt1 = (m_cnt1 + 1) % 256; end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("m_in_ready", 32'(bus.in_ready),
        32'(bus.in_sel ? (q1.size() < 2) : (q0.size() < 2)));
    chk("m_out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
    chk("m_out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
    if (q0.size() != 0) chk("m_out0_data", 32'(bus.out0_data), 32'(q0[0]));
    if (q1.size() != 0) chk("m_out1_data", 32'(bus.out1_data), 32'(q1[0]));
    chk("m_cnt0", 32'(bus.cnt0), 32'(m_cnt0));
    chk("m_cnt1", 32'(bus.cnt1), 32'(m_cnt1));
  end

  task automatic drive(input logic v, input logic sel, input logic [7:0] d,
                       input logic r0, input logic r1);
    bus.in_valid   = v;
    bus.in_sel     = sel;
    bus.in_data    = d;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    drive(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

    // Reset with random inputs: outputs cleared before any clock edge.
    #2;
    drive(1'b1, 1'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    #1;
    chk("rst_out0_valid", 32'(bus.out0_valid), 32'h0);
    chk("rst_out1_valid", 32'(bus.out1_valid), 32'h0);
    chk("rst_out0_data",  32'(bus.out0_data),  32'h0);
    chk("rst_out1_data",  32'(bus.out1_data),  32'h0);
    chk("rst_cnt0",       32'(bus.cnt0),       32'h0);
    chk("rst_cnt1",       32'(bus.cnt1),       32'h0);
    chk("rst_in_ready",   32'(bus.in_ready),   32'h1);
    tick();
    tick();
    chk("rst_held_out0_valid", 32'(bus.out0_valid), 32'h0);
    reset_n = 1'b1;

    // Routing.
    drive(1'b1, 1'b0, 8'hA5, 1'b1, 1'b1);
    tick();
    chk("route_out0_valid", 32'(bus.out0_valid), 32'h1);
    chk("route_out0_data",  32'(bus.out0_data),  32'hA5);
    chk("route_cnt0",       32'(bus.cnt0),       32'h1);
    drive(1'b1, 1'b1, 8'h3C, 1'b1, 1'b1);
    tick();
    chk("route_out1_valid", 32'(bus.out1_valid), 32'h1);
    chk("route_out1_data",  32'(bus.out1_data),  32'h3C);
    chk("route_out0_drained", 32'(bus.out0_valid), 32'h0);
    chk("route_cnt1",       32'(bus.cnt1),       32'h1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();

    // Full channel 0 stalls only its own words.
    drive(1'b1, 1'b0, 8'h11, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h22, 1'b0, 1'b1);
    tick();
    drive(1'b1, 1'b0, 8'h33, 1'b0, 1'b1);
    #1;
    chk("full_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("full_head_held", 32'(bus.out0_data), 32'h11);
    chk("full_cnt0",      32'(bus.cnt0),      32'h3);
    drive(1'b1, 1'b1, 8'h44, 1'b0, 1'b1);
    #1;
    chk("other_in_ready", 32'(bus.in_ready), 32'h1);
    tick();
    chk("other_out1_data", 32'(bus.out1_data), 32'h44);
    drive(1'b1, 1'b0, 8'h33, 1'b1, 1'b1);
    tick();
    chk("release_data1", 32'(bus.out0_data), 32'h22);
    chk("release_cnt0",  32'(bus.cnt0),      32'h3);
    tick();
    chk("release_data2", 32'(bus.out0_data), 32'h33);
    chk("release_cnt0b", 32'(bus.cnt0),      32'h4);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    chk("release_empty", 32'(bus.out0_valid), 32'h0);

    // Full channel 1 with simultaneous pop: no pass-through push.
    drive(1'b1, 1'b1, 8'h55, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h66, 1'b1, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
    #1;
    chk("fullpop_in_ready", 32'(bus.in_ready), 32'h0);
    tick();
    chk("fullpop_head",  32'(bus.out1_data), 32'h66);
    chk("fullpop_cnt1",  32'(bus.cnt1),      32'h4);
    chk("fullpop_ready", 32'(bus.in_ready),  32'h1);
    tick();
    chk("fullpop_next",  32'(bus.out1_data), 32'h77);
    chk("fullpop_cnt1b", 32'(bus.cnt1),      32'h5);
    drive(1'b0, 1'b1, 8'h00, 1'b1, 1'b1);
    tick();

    // Steady state from a fresh reset: 300 words through channel 0.
    #1;
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 8'h5A, 1'b0, 1'b1);
    tick();
    for (int i = 1; i < 300; i++) begin
      drive(1'b1, 1'b0, 8'(i) ^ 8'h5A, 1'b1, 1'b1);
      tick();
      chk("steady_out0_valid", 32'(bus.out0_valid), 32'h1);
    end
    chk("steady_cnt0", 32'(bus.cnt0), 32'd44);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    chk("steady_drained", 32'(bus.out0_valid), 32'h0);

    // Reset mid-stream with both FIFOs full.
    drive(1'b1, 1'b0, 8'h81, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 8'h82, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h91, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 8'h92, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_pre_out1_valid", 32'(bus.out1_valid), 32'h1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_out0_valid", 32'(bus.out0_valid), 32'h0);
    chk("mid_out1_valid", 32'(bus.out1_valid), 32'h0);
    chk("mid_out0_data",  32'(bus.out0_data),  32'h0);
    chk("mid_out1_data",  32'(bus.out1_data),  32'h0);
    chk("mid_cnt0",       32'(bus.cnt0),       32'h0);
    chk("mid_in_ready",   32'(bus.in_ready),   32'h1);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 8'hC3, 1'b1, 1'b1);
    tick();
    chk("after_rst_first_push", 32'(bus.out0_data), 32'hC3);
    chk("after_rst_no_stale1",  32'(bus.out1_valid), 32'h0);
    chk("after_rst_cnt0",       32'(bus.cnt0),      32'h1);
    drive(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    tick();
    chk("after_rst_empty", 32'(bus.out0_valid), 32'h0);
    chk("after_rst_ready", 32'(bus.in_ready),   32'h1);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/demux2r_stream.md
DEMUX2R_STREAM -- requirements
Module: demux2r_stream

Interface
REQ-001 Parameter: dw, default 8, width of the data path in bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 in_data  input  dw  word offered by the upstream source.
REQ-005 in_sel  input  1  destination channel for in_data: 0 = channel 0, 1 = channel 1.
REQ-006 in_valid  input  1  upstream word is present.
REQ-007 in_ready  output  1  block accepts the offered word this cycle.
REQ-008 out0_data  output  dw  head word of the channel 0 buffer.
REQ-009 out0_valid  output  1  channel 0 holds at least one word.
REQ-010 out0_ready  input  1  channel 0 sink consumes this cycle.
REQ-011 out1_data  output  dw  head word of the channel 1 buffer.
REQ-012 out1_valid  output  1  channel 1 holds at least one word.
REQ-013 out1_ready  input  1  channel 1 sink consumes this cycle.
REQ-014 cnt0  output  8  count of words accepted for channel 0.
REQ-015 cnt1  output  8  count of words accepted for channel 1.

Function
REQ-016 Each channel SHALL own an independent 2-entry FIFO. Each FIFO holds a data array, read pointer, write pointer and a 2-bit occupancy (0..2).
REQ-017 in_ready SHALL be combinational: in_ready = (occupancy of FIFO[in_sel] != 2). It SHALL be valid even when in_valid = 0.
REQ-018 A push SHALL occur on a clock edge with in_valid & in_ready. in_data is written into FIFO[in_sel].
REQ-019 A pushed word SHALL appear on outN_data/outN_valid on the cycle after the push. Latency is 1 cycle and there is no combinational path from in_data to out data.
REQ-020 outN_valid SHALL equal (occupancy N != 0). outN_data SHALL equal the entry at the read pointer of FIFO N.
REQ-021 A pop SHALL occur on a clock edge with outN_valid & outN_ready. The read pointer advances and occupancy decrements.
REQ-022 outN_data SHALL be held stable while outN_valid = 1 and outN_ready = 0.
REQ-023 A simultaneous push and pop on the same channel with occupancy 1 SHALL leave occupancy at 1 and preserve FIFO order.
REQ-024 When a FIFO is full, a pop on that edge SHALL NOT enable a push on the same edge. in_ready depends only on the current occupancy, with no pass-through.
REQ-025 A full channel SHALL stall only words selected for it. A word selected for the other, non-full channel SHALL be accepted.
REQ-026 Pointers SHALL wrap 1 -> 0. Word order within each channel SHALL equal acceptance order.
REQ-027 in_sel and in_data SHALL be ignored when in_valid = 0. outN_ready SHALL be ignored when outN_valid = 0.
REQ-028 cntN SHALL increment by 1 on each push to channel N and wrap 255 -> 0. Channels SHALL be counted independently.
REQ-029 No word SHALL be dropped, duplicated or delivered to the non-selected channel.

Reset
REQ-030 When reset_n = 0, the block SHALL immediately, without waiting for clk, clear to zero:
- all occupancies and pointers
- out0_valid and out1_valid
- out0_data and out1_data
- cnt0 and cnt1
REQ-031 During and after reset, in_ready SHALL be 1 because both FIFOs are empty.
REQ-032 Reset asserted mid-operation SHALL discard all buffered words. No handshake SHALL complete while reset_n = 0.
REQ-033 The first push after deassertion SHALL be accepted on the first clock edge with reset_n = 1.

Verification
REQ-034 Reset check: assert reset_n = 0 with random inputs -> both outN_valid = 0, both outN_data = 0, cnt0 = cnt1 = 0, in_ready = 1, with no clock edge required.
REQ-035 Routing: push 0xA5 with sel 0, then 0x3C with sel 1, both sinks ready -> out0 delivers 0xA5 one cycle after its push, out1 delivers 0x3C one cycle after its push; cnt0 = 1, cnt1 = 1.
REQ-036 Full and stall: hold out0_ready = 0 and push 0x11, 0x22, then offer 0x33 with sel 0 -> in_ready = 0 on the third word. Then offer 0x44 with sel 1 -> accepted. Release out0_ready -> out0 delivers 0x11, 0x22, 0x33 in order.
REQ-037 Full with simultaneous pop: channel 1 full, out1_ready = 1, in_valid = 1, in_sel = 1 -> no push on that edge; pop occurs; occupancy becomes 1; the push is accepted on the next edge.
REQ-038 Steady state and counter wrap: occupancy 1, push and pop every cycle for 300 words on channel 0 -> out0_valid stays 1 and all data is in order; cnt0 = 300 mod 256 = 44.
REQ-039 Reset mid-stream: both FIFOs holding 2 words, pulse reset_n low between edges -> outputs clear immediately; after release no stale word appears; in_ready = 1.
